// File: rtl/cc_mux_scan.sv
// cc_mux_scan: direct-select / auto-scan channel multiplexer with registered outputs
module cc_mux_scan #(
  parameter int MUXSCAN_CHANNELS    = 8,
  parameter int MUXSCAN_SELECTWIDTH = 3,
  parameter int MUXSCAN_DATAWIDTH   = 8,
  parameter int MUXSCAN_DWELLWIDTH  = 16
) (
  input  logic                                             CC_MUX_SCAN_CLOCK_50,
  input  logic                                             CC_MUX_SCAN_RESET_InHigh,
  input  logic                                             CC_MUX_SCAN_mode_In,
  input  logic                                             CC_MUX_SCAN_enable_In,
  input  logic [MUXSCAN_SELECTWIDTH-1:0]                   CC_MUX_SCAN_select_InBUS,
  input  logic [MUXSCAN_CHANNELS*MUXSCAN_DATAWIDTH-1:0]    CC_MUX_SCAN_data_InBUS,
  input  logic [MUXSCAN_DWELLWIDTH-1:0]                    CC_MUX_SCAN_dwell_InBUS,
  output logic [MUXSCAN_DATAWIDTH-1:0]                     CC_MUX_SCAN_z_OutBUS,
  output logic [MUXSCAN_SELECTWIDTH-1:0]                   CC_MUX_SCAN_channel_OutBUS,
  output logic                                             CC_MUX_SCAN_strobe_Out,
  output logic                                             CC_MUX_SCAN_wrap_Out
);
  localparam int N = MUXSCAN_CHANNELS;
  localparam int S = MUXSCAN_SELECTWIDTH;
  localparam int W = MUXSCAN_DATAWIDTH;
  localparam int D = MUXSCAN_DWELLWIDTH;
  logic [S-1:0] chan_q, chan_d, sel_c;
  logic [D-1:0] cnt_q, cnt_d;
  logic [W-1:0] z_q, z_d;
  logic mode_q, mode_d, strobe_q, strobe_d, wrap_q, wrap_d;
  logic entry, adv, last;
  always_comb begin
    sel_c    = (32'(CC_MUX_SCAN_select_InBUS) >= N) ? S'(N - 1) : CC_MUX_SCAN_select_InBUS;
    last     = 32'(chan_q) == N - 1;
    entry    = CC_MUX_SCAN_mode_In && !mode_q;
    // >= lets a shrinking dwell force an advance instead of waiting for counter wrap
    adv      = CC_MUX_SCAN_mode_In && mode_q && CC_MUX_SCAN_enable_In && cnt_q >= CC_MUX_SCAN_dwell_InBUS;
    chan_d   = !CC_MUX_SCAN_mode_In ? sel_c : entry ? '0 : adv ? (last ? '0 : chan_q + 1'b1) : chan_q;
    cnt_d    = (!CC_MUX_SCAN_mode_In || entry || adv) ? '0 : CC_MUX_SCAN_enable_In ? cnt_q + 1'b1 : cnt_q;
    strobe_d = !CC_MUX_SCAN_mode_In ? (sel_c != chan_q) : (entry || adv);
    wrap_d   = adv && last;
    mode_d   = CC_MUX_SCAN_mode_In;
    z_d      = '0;
    for (int k = 0; k < N; k++) z_d = (32'(chan_d) == k) ? CC_MUX_SCAN_data_InBUS[k*W +: W] : z_d;
  end
  always_ff @(posedge CC_MUX_SCAN_CLOCK_50) begin
    if (CC_MUX_SCAN_RESET_InHigh) begin
      chan_q   <= '0;
      cnt_q    <= '0;
      z_q      <= '0;
      mode_q   <= 1'b0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      chan_q   <= chan_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
      mode_q   <= mode_d;
      strobe_q <= strobe_d;
      wrap_q   <= wrap_d;
    end
  end
  assign CC_MUX_SCAN_z_OutBUS       = z_q;
  assign CC_MUX_SCAN_channel_OutBUS = chan_q;
  assign CC_MUX_SCAN_strobe_Out     = strobe_q;
  assign CC_MUX_SCAN_wrap_Out       = wrap_q;
endmodule

// File: tb/tb_cc_mux_scan.sv
// tb_cc_mux_scan: randomized and directed checks of cc_mux_scan against a behavioural model
module tb_cc_mux_scan;
  logic        clk = 0, rst = 1, mode = 0, en = 0;
  logic [2:0]  sel = 0;
  logic [63:0] data = 0;
  logic [15:0] dwell = 0;
  logic [7:0]  z, z6;
  logic [2:0]  ch, ch6;
  logic        st, wr, st6, wr6;
  int n_checks = 0, n_fail = 0;
  int m_ch = 0, m_cnt = 0, m_mode = 0, m_z = 0, m_strobe = 0, m_wrap = 0;

  always #5 clk = ~clk;

  cc_mux_scan dut (
    .CC_MUX_SCAN_CLOCK_50(clk), .CC_MUX_SCAN_RESET_InHigh(rst), .CC_MUX_SCAN_mode_In(mode),
    .CC_MUX_SCAN_enable_In(en), .CC_MUX_SCAN_select_InBUS(sel), .CC_MUX_SCAN_data_InBUS(data),
    .CC_MUX_SCAN_dwell_InBUS(dwell), .CC_MUX_SCAN_z_OutBUS(z), .CC_MUX_SCAN_channel_OutBUS(ch),
    .CC_MUX_SCAN_strobe_Out(st), .CC_MUX_SCAN_wrap_Out(wr));

  cc_mux_scan #(.MUXSCAN_CHANNELS(6)) dut6 (
    .CC_MUX_SCAN_CLOCK_50(clk), .CC_MUX_SCAN_RESET_InHigh(rst), .CC_MUX_SCAN_mode_In(mode),
    .CC_MUX_SCAN_enable_In(en), .CC_MUX_SCAN_select_InBUS(sel), .CC_MUX_SCAN_data_InBUS(data[47:0]),
    .CC_MUX_SCAN_dwell_InBUS(dwell), .CC_MUX_SCAN_z_OutBUS(z6), .CC_MUX_SCAN_channel_OutBUS(ch6),
    .CC_MUX_SCAN_strobe_Out(st6), .CC_MUX_SCAN_wrap_Out(wr6));

  // Reference model of the 8-channel instance, stepped once per rising edge from the driven inputs
  task automatic model_edge();
    int nc;
    if (rst) begin
      m_ch = 0; m_cnt = 0; m_mode = 0; m_z = 0; m_strobe = 0; m_wrap = 0;
      return;
    end
    nc = m_ch;
    if (!mode) begin
      nc = (int'(sel) >= 8) ? 7 : int'(sel);
      m_strobe = int'(nc != m_ch); m_wrap = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      nc = 0; m_cnt = 0; m_strobe = 1; m_wrap = 0;
    end else if (en && m_cnt >= int'(dwell)) begin
      nc = (m_ch + 1) % 8; m_cnt = 0; m_strobe = 1; m_wrap = int'(m_ch == 7);
    end else begin
      if (en) m_cnt = m_cnt + 1;
      m_strobe = 0; m_wrap = 0;
    end
    m_mode = int'(mode);
    m_ch = nc;
    m_z = int'(data[nc*8 +: 8]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; mode = 1; en = 1; sel = 5; dwell = 1; data = {$urandom, $urandom};
    tick(); tick();
    n_checks++;
    if ({z, ch, st, wr} !== 13'h0) begin
      n_fail++; $display("FAIL reset_state: got %h expected 0", {z, ch, st, wr});
    end
    rst = 0; mode = 0; sel = 0;
    tick();
    n_checks++;
    if ({ch, st, wr} !== 5'h0) begin
      n_fail++; $display("FAIL reset_release_direct0: got %h expected 0", {ch, st, wr});
    end
  endtask

  task automatic test_direct();
    mode = 0; sel = 5; data = {$urandom, $urandom}; data[47:40] = 8'hA5;
    tick();
    n_checks++;
    if ({z, ch, st, wr} !== {8'hA5, 3'd5, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL direct_sel5: got %h expected %h", {z, ch, st, wr}, {8'hA5, 3'd5, 1'b1, 1'b0});
    end
    tick();
    n_checks++;
    if ({ch, st} !== {3'd5, 1'b0}) begin
      n_fail++; $display("FAIL direct_hold: got %h expected %h", {ch, st}, {3'd5, 1'b0});
    end
    for (int i = 0; i < 20; i++) begin
      sel = 3'($urandom); data = {$urandom, $urandom};
      tick();
      n_checks++;
      if ({z, ch, st, wr} !== {8'(m_z), 3'(m_ch), 1'(m_strobe), 1'(m_wrap)}) begin
        n_fail++; $display("FAIL direct_random: got %h expected %h", {z, ch, st, wr}, {8'(m_z), 3'(m_ch), 1'(m_strobe), 1'(m_wrap)});
      end
    end
  endtask

  task automatic test_clamp();
    mode = 0; sel = 7; data = {$urandom, $urandom}; data[47:40] = 8'h3C;
    tick();
    n_checks++;
    if ({z6, ch6} !== {8'h3C, 3'd5}) begin
      n_fail++; $display("FAIL clamp_sel7: got %h expected %h", {z6, ch6}, {8'h3C, 3'd5});
    end
    sel = 3;
    tick();
    n_checks++;
    if ({z6, ch6, st6} !== {data[31:24], 3'd3, 1'b1}) begin
      n_fail++; $display("FAIL clamp_sel3: got %h expected %h", {z6, ch6, st6}, {data[31:24], 3'd3, 1'b1});
    end
  endtask

  task automatic test_scan_seq();
    logic [4:0] exp;
    mode = 1; en = 1; dwell = 2;
    for (int i = 0; i <= 24; i++) begin
      data = {$urandom, $urandom};
      tick();
      exp = {3'((i / 3) % 8), 1'(i % 3 == 0), 1'(i % 3 == 0 && i > 0 && (i / 3) % 8 == 0)};
      n_checks++;
      if ({ch, st, wr} !== exp) begin
        n_fail++; $display("FAIL scan_seq[%0d]: got %h expected %h", i, {ch, st, wr}, exp);
      end
      n_checks++;
      if (z !== data[int'(exp[4:2])*8 +: 8]) begin
        n_fail++; $display("FAIL scan_seq_z[%0d]: got %h expected %h", i, z, data[int'(exp[4:2])*8 +: 8]);
      end
    end
  endtask

  task automatic test_dwell0_freeze();
    int c;
    dwell = 0; en = 1;
    for (int i = 0; i < 10; i++) begin
      data = {$urandom, $urandom};
      tick();
      n_checks++;
      if ({z, ch, st, wr} !== {8'(m_z), 3'(m_ch), 1'(m_strobe), 1'(m_wrap)} || !st) begin
        n_fail++; $display("FAIL dwell0_step: got %h expected %h", {z, ch, st, wr}, {8'(m_z), 3'(m_ch), 1'b1, 1'(m_wrap)});
      end
    end
    c = int'(ch); en = 0;
    for (int i = 0; i < 3; i++) begin
      data = {$urandom, $urandom};
      tick();
      n_checks++;
      if ({z, ch, st, wr} !== {data[c*8 +: 8], 3'(c), 2'b00}) begin
        n_fail++; $display("FAIL freeze: got %h expected %h", {z, ch, st, wr}, {data[c*8 +: 8], 3'(c), 2'b00});
      end
    end
    en = 1;
    tick();
    n_checks++;
    if ({ch, st} !== {3'((c + 1) % 8), 1'b1}) begin
      n_fail++; $display("FAIL freeze_resume: got %h expected %h", {ch, st}, {3'((c + 1) % 8), 1'b1});
    end
  endtask

  task automatic test_dwell_shrink();
    mode = 0; sel = 0;
    tick();
    mode = 1; en = 1; dwell = 10;
    tick();
    repeat (7) tick();
    n_checks++;
    if ({ch, st} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL shrink_before: got %h expected %h", {ch, st}, {3'd0, 1'b0});
    end
    dwell = 3;
    tick();
    n_checks++;
    if ({ch, st, wr} !== {3'd1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL shrink_advance: got %h expected %h", {ch, st, wr}, {3'd1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    mode = 0; sel = 0;
    tick();
    mode = 1; en = 1; dwell = 2;
    tick();
    repeat (13) tick();
    n_checks++;
    if (ch !== 3'd4) begin
      n_fail++; $display("FAIL mid_reach_ch4: got %h expected 4", ch);
    end
    rst = 1;
    tick();
    n_checks++;
    if ({z, ch, st, wr} !== 13'h0) begin
      n_fail++; $display("FAIL mid_reset: got %h expected 0", {z, ch, st, wr});
    end
    rst = 0;
    tick();
    n_checks++;
    if ({ch, st, wr} !== {3'd0, 1'b1, 1'b0} || z !== data[7:0]) begin
      n_fail++; $display("FAIL reset_scan_entry: got %h expected %h", {z, ch, st, wr}, {data[7:0], 3'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 19) == 0) dwell = 16'($urandom_range(0, 4));
      en = ($urandom_range(0, 3) != 0);
      sel = 3'($urandom);
      data = {$urandom, $urandom};
      tick();
      n_checks++;
      if ({z, ch, st, wr} !== {8'(m_z), 3'(m_ch), 1'(m_strobe), 1'(m_wrap)}) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, {z, ch, st, wr}, {8'(m_z), 3'(m_ch), 1'(m_strobe), 1'(m_wrap)});
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_clamp();
    test_scan_seq();
    test_dwell0_freeze();
    test_dwell_shrink();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cc_mux_scan.md
CC_MUX_SCAN -- requirements
Module: cc_mux_scan

Interface
REQ-001 Parameter MUXSCAN_CHANNELS, default 8, SHALL set the number of input channels N (2..256).
REQ-002 Parameter MUXSCAN_SELECTWIDTH, default 3, SHALL set select/channel width S (S >= ceil(log2 N)).
REQ-003 Parameter MUXSCAN_DATAWIDTH, default 8, SHALL set per-channel data width W.
REQ-004 Parameter MUXSCAN_DWELLWIDTH, default 16, SHALL set dwell counter width D.
REQ-005 Port CC_MUX_SCAN_CLOCK_50  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port CC_MUX_SCAN_RESET_InHigh  in  1  SHALL be a synchronous, active-high reset.
REQ-007 Port CC_MUX_SCAN_mode_In  in  1  SHALL select the mode: 0 = direct select, 1 = auto-scan.
REQ-008 Port CC_MUX_SCAN_enable_In  in  1  SHALL gate scan advance; it has no effect in direct mode.
REQ-009 Port CC_MUX_SCAN_select_InBUS  in  S  SHALL give the channel index in direct mode.
REQ-010 Port CC_MUX_SCAN_data_InBUS  in  N*W  SHALL carry the channels; channel k occupies bits [k*W+W-1 : k*W].
REQ-011 Port CC_MUX_SCAN_dwell_InBUS  in  D  SHALL set the scan dwell; each channel is held for dwell+1 enabled cycles.
REQ-012 Port CC_MUX_SCAN_z_OutBUS  out  W  SHALL be the registered data of the current channel.
REQ-013 Port CC_MUX_SCAN_channel_OutBUS  out  S  SHALL be the registered current channel index.
REQ-014 Port CC_MUX_SCAN_strobe_Out  out  1  SHALL pulse for one cycle in the cycle the channel output takes a new value.
REQ-015 Port CC_MUX_SCAN_wrap_Out  out  1  SHALL pulse for one cycle in the cycle the scan wraps from channel N-1 to 0.

Function
REQ-016 Internal state SHALL be the channel register, the dwell counter (D bits), a registered copy of mode, z, strobe and wrap.
REQ-017 Latency SHALL be one cycle; z always equals data[channel_OutBUS] sampled on the same edge that loaded channel_OutBUS.
REQ-018 Direct mode: channel <= clamp(select), where clamp maps any select >= N to N-1.
REQ-019 Direct mode: the dwell counter <= 0 and wrap <= 0.
REQ-020 Direct mode: strobe <= 1 if and only if clamp(select) differs from the current channel.
REQ-021 Scan entry (mode 1 now, registered mode 0): channel <= 0, counter <= 0, strobe <= 1, wrap <= 0, regardless of enable.
REQ-022 Scan with enable = 1 and counter >= dwell: counter <= 0 and channel <= channel+1, or 0 if channel = N-1.
REQ-023 In the REQ-022 advance case, strobe <= 1, and wrap <= 1 if and only if the old channel = N-1.
REQ-024 Scan with enable = 1 and counter < dwell: counter <= counter+1; channel held; strobe = wrap = 0.
REQ-025 Scan with enable = 0: counter and channel SHALL be frozen, strobe = wrap = 0, and z SHALL keep tracking live data of the held channel.
REQ-026 dwell = 0 SHALL advance the channel every enabled cycle.
REQ-027 The compare SHALL be >=, so reducing dwell below the current count forces an advance on the next enabled cycle.
REQ-028 Scan to direct: the select path SHALL apply on the first cycle mode = 0, with no extra delay.
REQ-029 Data changes on the current channel SHALL appear on z one cycle later in every mode and SHALL NOT generate strobe.

Reset
REQ-030 While reset = 1 at a clock edge, outputs and state SHALL load: channel 0, counter 0, z 0, strobe 0, wrap 0, registered mode 0.
REQ-031 Reset SHALL override mode, enable and select, and SHALL take effect mid-dwell or mid-scan.
REQ-032 With mode = 1 at reset release, the first cycle SHALL be a scan entry per REQ-021.

Verification
REQ-033 Defaults; direct mode; select 5 with ch5 = 0xA5 -> next cycle channel 5, z 0xA5, strobe 1; hold select -> strobe 0.
REQ-034 Direct mode; select 7 with N = 6 -> channel 5, z = data ch5.
REQ-035 Scan; dwell 2; enable 1 -> channel sequence 0,0,0,1,1,1,...,7,7,7,0.
REQ-036 Scan; dwell 2; enable 1 (continued) -> strobe on every channel change; wrap only on the 7 to 0 change.
REQ-037 Scan; dwell 0 -> channel increments every cycle; enable low for 3 cycles mid-scan -> channel and counter frozen, z follows live data.
REQ-038 Reset at count 1 of channel 4 -> next cycle all outputs 0.
REQ-039 Scan; dwell 10, counter 7; dwell changed to 3 -> advance on next enabled cycle.
